// File: rtl/disp_pkg.sv
// Shared types and helpers for the hex display scan controller.
package disp_pkg;

  typedef enum logic [1:0] {ST_OFF, ST_SHOW, ST_GUARD} scan_state_t;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  function automatic logic [MAX_DIGITS-1:0] onehot_sel(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/refresh_timer.sv
// Phase timer: restarts from 0 on clear and raises tick while the count sits at the loaded terminal value.
module refresh_timer #(
  parameter int MAX   = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] term;

  // Saturates at the terminal count so tick stays valid until the owner clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      term  <= '0;
    end else if (clear) begin
      count <= '0;
      term  <= load_val;
    end else if (count != term) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == term);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex digit scanner feeding seven_seg, with guard gaps and tear-free frame updates.
// Build option: LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shown).
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    enable,
  output logic [3:0]              nibble,
  output logic                    seg_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  import disp_pkg::*;

  localparam int VAL_W   = NIBBLE_W * NUM_DIGITS;
  localparam int TMR_MAX = REFRESH_DIV + GUARD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SHOW_TERM  = TMR_W'(REFRESH_DIV - 1);
  localparam logic [TMR_W-1:0] GUARD_TERM = TMR_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic              rst_sync_n;
  scan_state_t       state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [VAL_W-1:0]  pending, shadow, shadow_next, capture;
  logic              tmr_clear, tmr_tick, slot_end, frame_end;
  logic [TMR_W-1:0]  tmr_load;
  logic [NUM_DIGITS-1:0] sel_d;
  logic              en_d;
  logic [3:0]        nib_d;

  // Reset asserts immediately but releases one edge later, clean of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_n <= 1'b0;
    else        rst_sync_n <= 1'b1;
  end

  refresh_timer #(.MAX(TMR_MAX), .CNT_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_sync_n),
    .clear    (tmr_clear),
    .load_val (tmr_load),
    .tick     (tmr_tick)
  );

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state   <= ST_OFF;
      idx     <= '0;
      pending <= '0;
      shadow  <= '0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      shadow <= shadow_next;
      if (load) pending <= value;
    end
  end

  // A load in the very cycle the shadow is refreshed must reach the new frame
  assign capture = load ? value : pending;

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    shadow_next = shadow;
    tmr_clear   = 1'b0;
    tmr_load    = SHOW_TERM;
    slot_end    = 1'b0;
    frame_end   = 1'b0;
    if (!enable) begin
      state_next = ST_OFF;
      idx_next   = '0;
      tmr_clear  = 1'b1;
      tmr_load   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_next  = ST_SHOW;
          idx_next    = '0;
          tmr_clear   = 1'b1;
          shadow_next = capture;
        end
        ST_SHOW: begin
          if (tmr_tick) begin
            if (GUARD_CYCLES > 0) begin
              state_next = ST_GUARD;
              tmr_clear  = 1'b1;
              tmr_load   = GUARD_TERM;
            end else begin
              slot_end = 1'b1;
            end
          end
        end
        ST_GUARD: slot_end = tmr_tick;
        default:  state_next = ST_OFF;
      endcase
      if (slot_end) begin
        state_next = ST_SHOW;
        tmr_clear  = 1'b1;
        frame_end  = (idx == IDX_LAST);
        idx_next   = frame_end ? '0 : idx + IDX_W'(1);
        if (frame_end) shadow_next = capture;
      end
    end
  end

  // Outputs are precomputed from the upcoming state so they change on the entering edge
  always_comb begin
    sel_d = '0;
    en_d  = 1'b0;
    nib_d = nibble;
    case (state_next)
      ST_SHOW: begin
        nib_d = shadow_next[int'(idx_next) * NIBBLE_W +: NIBBLE_W];
        sel_d = NUM_DIGITS'(onehot_sel(3'(idx_next)));
        en_d  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_next != '0 && (shadow_next >> (NIBBLE_W * int'(idx_next))) == '0) begin
          sel_d = '0;
          en_d  = 1'b0;
        end
`endif
      end
      ST_OFF:  nib_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      nibble     <= '0;
      seg_en     <= 1'b0;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      nibble     <= nib_d;
      seg_en     <= en_d;
      digit_sel  <= sel_d;
      frame_done <= frame_end;
    end
  end

  assign digit_idx = idx;

endmodule
